// File: rtl/tb_rst_seq.sv
// Staged reset sequencer: fans one synchronous reset out as NSTAGES ordered,
// staggered active-high resets, with a soft-restart request and ready/busy status.
module tb_rst_seq #(
    parameter int unsigned NSTAGES = 3,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned GAP     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_req,
    output logic [NSTAGES-1:0] stage_reset,
    output logic               ready,
    output logic               busy
);

    localparam int unsigned Last = HOLD + (NSTAGES - 1) * GAP;
    localparam int unsigned CntW = $clog2(Last + 1) + 1;

    if (NSTAGES < 1) begin : g_bad_nstages
        $error("tb_rst_seq: NSTAGES must be >= 1");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("tb_rst_seq: HOLD must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("tb_rst_seq: GAP must be >= 1");
    end

    typedef enum logic [1:0] {
        StAssert,
        StHold,
        StRelease,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NSTAGES-1:0]  stage_q, stage_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                seq_active;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        seq_active = 1'b1;

        unique case (state_q)
            StAssert: cnt_d = CntW'(1);
            StHold, StRelease: begin
                if (soft_req) cnt_d = CntW'(1);
                else          cnt_d = cnt_q + CntW'(1);
            end
            StDone: begin
                if (soft_req) cnt_d = CntW'(1);
                else          seq_active = 1'b0;
            end
            default: cnt_d = '0;
        endcase

        // Every stage and the state are pure functions of the edge count within
        // the sequence, so a restart simply rewinds cnt to 1.
        if (seq_active) begin
            for (int unsigned i = 0; i < NSTAGES; i++) begin
                stage_d[i] = (32'(cnt_d) < (HOLD + i * GAP));
            end
            if (32'(cnt_d) >= Last)      state_d = StDone;
            else if (32'(cnt_d) >= HOLD) state_d = StRelease;
            else                         state_d = StHold;
        end

        ready_d = (stage_d == '0);
        busy_d  = (state_d == StHold) || (state_d == StRelease);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            stage_q <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign stage_reset = stage_q;
    assign ready       = ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tb_rst_seq.sv
// Bench for tb_rst_seq: default instance plus an NSTAGES=1/HOLD=3 instance, checked
// every edge against an edge-count reference model, directed steps then random stimulus.
module tb_tb_rst_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       soft_req = 1'b0;
    logic [2:0] st_a;
    logic       rdy_a, bsy_a;
    logic [0:0] st_b;
    logic       rdy_b, bsy_b;

    int checks = 0;
    int passes = 0;
    // Edges since the current sequence began (0 = held in reset).
    int ka = 0;
    int kb = 0;

    always #5 clk = ~clk;

    tb_rst_seq #(.NSTAGES(3), .HOLD(2), .GAP(4)) u_dut_a (
        .clk(clk), .reset(reset), .soft_req(soft_req),
        .stage_reset(st_a), .ready(rdy_a), .busy(bsy_a)
    );

    tb_rst_seq #(.NSTAGES(1), .HOLD(3), .GAP(4)) u_dut_b (
        .clk(clk), .reset(reset), .soft_req(soft_req),
        .stage_reset(st_b), .ready(rdy_b), .busy(bsy_b)
    );

    function automatic logic [7:0] exp_stage(int k, int n, int hold, int gap);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (k == 0) || (k < hold + i * gap);
        return r;
    endfunction

    function automatic int next_k(int k, logic r, logic s);
        if (r)           return 0;
        else if (k == 0) return 1;
        else if (s)      return 1;
        else if (k < 1000) return k + 1;
        return k;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        logic [7:0] ea, eb;
        @(posedge clk);
        ka = next_k(ka, reset, soft_req);
        kb = next_k(kb, reset, soft_req);
        #1;
        ea = exp_stage(ka, 3, 2, 4);
        eb = exp_stage(kb, 1, 3, 4);
        chk("stage_a", 32'(st_a), 32'(ea[2:0]));
        chk("ready_a", 32'(rdy_a), 32'(ea[2:0] == 3'b000));
        chk("busy_a", 32'(bsy_a), 32'((ka != 0) && (ea[2:0] != 3'b000)));
        chk("stage_b", 32'(st_b), 32'(eb[0]));
        chk("ready_b", 32'(rdy_b), 32'(eb[0] == 1'b0));
        chk("busy_b", 32'(bsy_b), 32'((kb != 0) && eb[0]));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [2:0] tbl [1:10];

    initial begin
        tbl = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b110,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b000};

        // Power-on: reset for 5 cycles, then the default release timeline.
        reset = 1'b1;
        run(5);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e <= 10) chk("timeline_a", 32'(st_a), 32'(tbl[e]));
            chk("timeline_rdy_a", 32'(rdy_a), 32'(e >= 10));
            chk("timeline_b", 32'(st_b), 32'(e < 3));
        end

        // One-cycle soft request from DONE.
        soft_req = 1'b1;
        tick();
        chk("soft_edge", 32'(st_a), 32'(3'b111));
        soft_req = 1'b0;
        run(11);

        // Reset reasserted after edge 7, then a clean restart.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(7);
        reset = 1'b1;
        tick();
        chk("mid_reset", 32'(st_a), 32'(3'b111));
        reset = 1'b0;
        run(12);

        // Soft request held 6 cycles during RELEASE.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(4);
        soft_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("soft_hold", 32'(st_a), 32'(3'b111));
        end
        soft_req = 1'b0;
        run(12);

        // Soft request while reset is high has no effect.
        reset = 1'b1;
        soft_req = 1'b1;
        run(3);
        reset = 1'b0;
        soft_req = 1'b0;
        run(12);

        // Random reset / soft-request traffic.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            soft_req = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tb_rst_seq.md
Name: tb_rst_seq

Overview:
- Simulation-library reset sequencer sitting directly downstream of the testbench power-on-reset generator.
- Consumes the generator's clk and reset and fans them out as NSTAGES ordered, staggered reset lines, one per DUT domain: interconnect first, then cores, then peripherals.
- Signals "all released" to the bench.
- Lets the bench re-run the whole sequence with a soft reset request, without touching the power-on reset.

Parameters:
- NSTAGES, 3, number of staged reset outputs; must be >= 1.
- HOLD, 2, cycles after upstream reset deassertion before stage 0 releases; must be >= 1.
- GAP, 4, cycles between consecutive stage releases; must be >= 1.

Ports:
- clk  input  1  testbench clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset from the power-on-reset stage; overrides everything.
- soft_req  input  1  bench request to restart the sequence; level-sampled each edge.
- stage_reset  output  NSTAGES  per-domain active-high resets; bit i releases before bit i+1.
- ready  output  1  high when every stage_reset bit is low.
- busy  output  1  high while a sequence is in progress (HOLD or RELEASE state).

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- All outputs are registered.
- States:
  - ASSERT: reset held.
  - HOLD: waiting before first release.
  - RELEASE: stages dropping in order.
  - DONE: all stages released.
- Internal counter cnt:
  - Width $clog2(HOLD+(NSTAGES-1)*GAP+1)+1.
  - Saturates in DONE; no wrap.
- Reset (any edge where reset=1, in any state):
  - state=ASSERT, cnt=0.
  - stage_reset=all ones, ready=0, busy=0.
- ASSERT:
  - First edge sampling reset=0 goes to HOLD, cnt=1, busy=1.
- HOLD/RELEASE, on each edge with reset=0:
  - cnt increments.
  - stage_reset[i] clears on the edge where cnt reaches HOLD+i*GAP.
  - The state is RELEASE once stage 0 has cleared.
- Edge numbering for all timings: the first edge sampling reset=0 is edge 1.
  - stage_reset[i] is low after edge HOLD+i*GAP.
  - ready rises on the same edge stage_reset[NSTAGES-1] clears.
  - busy falls on that edge; the state becomes DONE.
- Release order is strictly monotonic; a higher bit never clears before a lower bit.
- DONE:
  - Holds stage_reset=0, ready=1, busy=0 until reset or soft_req.
- soft_req=1 sampled with reset=0, in HOLD, RELEASE or DONE:
  - On that edge stage_reset=all ones, ready=0, state=HOLD, cnt=1, busy=1.
  - The sequence then replays with the same timing, that edge acting as edge 1.
  - soft_req held high keeps restarting every edge, so all stages stay asserted.
- soft_req in ASSERT or with reset=1: ignored; reset wins.
- reset rising mid-sequence:
  - Next edge forces the full reset values.
  - No partial release survives.
- NSTAGES=1:
  - Single release at edge HOLD; GAP unused.
- Elaboration:
  - $error if NSTAGES<1, HOLD<1 or GAP<1.

Test Plan:
- Defaults; reset high 5 cycles then low:
  - stage_reset=111 through edge 1.
  - Stage 0 low after edge 2, stage 1 after edge 6, stage 2 after edge 10.
  - ready=1 and busy=0 after edge 10.
  - ready=0 on every earlier edge.
- In DONE, pulse soft_req one cycle:
  - stage_reset=111 and ready=0 on that edge.
  - Releases repeat at +1/+5/+9 edges after it.
- Reset reasserted after edge 7 (stage 0,1 released):
  - Next edge stage_reset=111, ready=0, busy=0.
  - Deassert again: timing restarts per first scenario.
- soft_req held high 6 cycles during RELEASE:
  - stage_reset stays 111 throughout.
  - After soft_req drops, releases at +1/+5/+9 edges from last sampled request.
- NSTAGES=1, HOLD=3:
  - stage_reset low and ready high after edge 3.
- soft_req=1 while reset=1:
  - No effect; outputs remain reset values.
  - Sequence starts normally at reset deassertion.
